// File: rtl/argmax_classifier.sv
// argmax_classifier: streaming FP32 argmax over a frame of N_CLASSES beats.
// Emits winning index/value with NaN and frame-length error flags.
module argmax_classifier #(
   parameter int N_CLASSES = 10,
   parameter int IDX_W     = $clog2(N_CLASSES)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_class,
   output logic [31:0]      out_value,
   output logic             out_nan,
   output logic             out_len_err
);

   typedef enum logic {ACC, RESULT} state_t;

   localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(N_CLASSES - 1);
   localparam logic [IDX_W:0] ONE      = (IDX_W+1)'(1);

   state_t state, state_nxt;

   logic [IDX_W:0]   cnt;
   logic [31:0]      best_val;
   logic [IDX_W-1:0] best_idx;
   logic             best_ok;
   logic             nan_flag;

   logic             beat, is_nan, take, last_cnt, term;
   logic [31:0]      canon;
   logic [31:0]      nxt_val;
   logic [IDX_W-1:0] nxt_idx;
   logic             nxt_ok, nxt_nan;

   // Monotonic unsigned key for FP32 ordering; input is already -0 canonicalised
   function automatic logic [31:0] key(input logic [31:0] b);
      return b[31] ? ~b : {1'b1, b[30:0]};
   endfunction

   assign in_ready  = (state == ACC);
   assign out_valid = (state == RESULT);

   assign beat     = in_valid & in_ready;
   assign canon    = (in_data == 32'h8000_0000) ? 32'h0 : in_data;
   assign is_nan   = (&in_data[30:23]) & (|in_data[22:0]);
   assign take     = beat & ~is_nan & (~best_ok | (key(canon) > key(best_val)));
   assign last_cnt = (cnt == LAST_CNT);
   assign term     = beat & (in_last | last_cnt);

   assign nxt_val = take ? canon : best_val;
   assign nxt_idx = take ? cnt[IDX_W-1:0] : best_idx;
   assign nxt_ok  = best_ok | take;
   assign nxt_nan = nan_flag | (beat & is_nan);

   always_ff @(posedge CLK) begin
      if (RST) state <= ACC;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ACC:    if (term)      state_nxt = RESULT;
         RESULT: if (out_ready) state_nxt = ACC;
         default:               state_nxt = ACC;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt         <= '0;
         best_val    <= '0;
         best_idx    <= '0;
         best_ok     <= 1'b0;
         nan_flag    <= 1'b0;
         out_class   <= '0;
         out_value   <= '0;
         out_nan     <= 1'b0;
         out_len_err <= 1'b0;
      end else begin
         if (beat) begin
            cnt      <= cnt + ONE;
            best_val <= nxt_val;
            best_idx <= nxt_idx;
            best_ok  <= nxt_ok;
            nan_flag <= nxt_nan;
         end
         if (term) begin
            // A frame with no ordered value reports the canonical quiet NaN
            out_class   <= nxt_ok ? nxt_idx : '0;
            out_value   <= nxt_ok ? nxt_val : 32'h7FC0_0000;
            out_nan     <= nxt_nan;
            out_len_err <= in_last ^ last_cnt;
         end
         if (out_valid && out_ready) begin
            cnt      <= '0;
            best_ok  <= 1'b0;
            nan_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed frames checked against a queue of
// expected results popped when the block presents out_valid.
module tb_argmax_classifier;

   localparam int N = 10;
   localparam int IW = $clog2(N);

   logic          CLK = 1'b0;
   logic          RST;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_class;
   logic [31:0]   out_value;
   logic          out_nan;
   logic          out_len_err;

   typedef struct {
      logic [31:0] cls;
      logic [31:0] val;
      logic        nan;
      logic        le;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] fr [N];
   int          n_checks = 0;
   int          n_fails  = 0;

   argmax_classifier #(.N_CLASSES(N)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_value(out_value),
      .out_nan(out_nan), .out_len_err(out_len_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] cls, input logic [31:0] val,
                           input logic nan, input logic le);
      exp_t e;
      e.cls = cls; e.val = val; e.nan = nan; e.le = le;
      sb.push_back(e);
   endtask

   // Sends fr[0..n-1]; in_last on the final beat if use_last; idle gap before gap_at
   task automatic send_frame(input string tag, input int n,
                             input bit use_last, input int gap_at);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            in_valid = 1'b0;
            in_data  = 32'h7F7F_FFFF;
            in_last  = 1'b1;
            tick();
            tick();
         end
         in_valid = 1'b1;
         in_data  = fr[i];
         in_last  = use_last && (i == n - 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk({tag, "_latency"}, out_valid, 1'b1);
   endtask

   task automatic get_result(input string tag);
      exp_t e;
      int   w = 0;
      while (out_valid !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      chk({tag, "_valid"}, out_valid, 1'b1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_class"}, out_class, e.cls);
      chk({tag, "_value"}, out_value, e.val);
      chk({tag, "_nan"}, out_nan, e.nan);
      chk({tag, "_len_err"}, out_len_err, e.le);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_ready_back"}, in_ready, 1'b1);
      chk({tag, "_valid_drop"}, out_valid, 1'b0);
   endtask

   initial begin
      RST = 1'b1; in_valid = 1'b0; in_data = '0;
      in_last = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_class", out_class, 0);
      chk("rst_value", out_value, 0);
      chk("rst_nan", out_nan, 1'b0);
      chk("rst_len_err", out_len_err, 1'b0);
      RST = 1'b0;
      tick();
      chk("post_rst_ready", in_ready, 1'b1);

      // Mixed frame with an idle gap mid-frame
      fr = '{32'h3F800000, 32'h40200000, 32'hC0400000, 32'h00000000,
             32'h40E80000, 32'h40E00000, 32'hFF800000, 32'h006CE3EE,
             32'h40C00000, 32'h3F000000};
      push_exp(4, 32'h40E80000, 1'b0, 1'b0);
      send_frame("basic", N, 1'b1, 5);
      get_result("basic");

      // Negative values with -0 at 2 and +0 at 6
      fr = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'hBF000000,
             32'hFF800000, 32'hC0400000, 32'h00000000, 32'hC0800000,
             32'h806CE3EE, 32'hC0A00000};
      push_exp(2, 32'h00000000, 1'b0, 1'b0);
      send_frame("szero", N, 1'b1, -1);
      get_result("szero");

      fr = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000,
             32'h00000000, 32'hBF800000, 32'h40800000, 32'h3F000000,
             32'h40A00000, 32'h40400000};
      push_exp(3, 32'h40A00000, 1'b0, 1'b0);
      send_frame("tie", N, 1'b1, -1);
      get_result("tie");

      fr = '{32'h7FC00001, 32'h3F800000, 32'h40000000, 32'hBF800000,
             32'h3F000000, 32'h00000000, 32'hC0000000, 32'h3FC00000,
             32'h40200000, 32'h40400000};
      push_exp(9, 32'h40400000, 1'b1, 1'b0);
      send_frame("nan", N, 1'b1, -1);
      get_result("nan");

      fr = '{32'h7FC00000, 32'hFFC00000, 32'h7F800001, 32'h7FFFFFFF,
             32'hFFFFFFFF, 32'hFF800001, 32'h7FC12345, 32'h7FA00000,
             32'hFFC00001, 32'h7F800002};
      push_exp(0, 32'h7FC00000, 1'b1, 1'b0);
      send_frame("allnan", N, 1'b1, -1);
      get_result("allnan");

      // Short frame: largest value sits past the end and must be ignored
      fr = '{32'h3F800000, 32'h40000000, 32'hC0000000, 32'h40800000,
             32'h3F000000, 32'h40400000, 32'h7F000000, 32'h00000000,
             32'h00000000, 32'h00000000};
      push_exp(3, 32'h40800000, 1'b0, 1'b1);
      send_frame("short", 6, 1'b1, -1);
      get_result("short");

      fr = '{32'h3F800000, 32'h40000000, 32'hC0000000, 32'h40800000,
             32'h3F000000, 32'h40400000, 32'h40E00000, 32'h00000000,
             32'hC1200000, 32'h41200000};
      push_exp(9, 32'h41200000, 1'b0, 1'b1);
      send_frame("nolast", N, 1'b0, -1);
      get_result("nolast");

      // Clean frame, then backpressure with offered beats
      fr = '{32'h3F800000, 32'h40200000, 32'hC0400000, 32'h00000000,
             32'h40E80000, 32'h40E00000, 32'hFF800000, 32'h006CE3EE,
             32'h40C00000, 32'h3F000000};
      push_exp(4, 32'h40E80000, 1'b0, 1'b0);
      send_frame("clean", N, 1'b1, -1);
      in_valid = 1'b1;
      in_data  = 32'h7F000000;
      in_last  = 1'b1;
      repeat (3) begin
         tick();
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_class", out_class, sb[0].cls);
         chk("bp_value", out_value, sb[0].val);
         chk("bp_len_err", out_len_err, sb[0].le);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      get_result("clean");

      fr = '{32'hC0000000, 32'h3F800000, 32'h40000000, 32'h00000000,
             32'h3F000000, 32'h40400000, 32'hBF800000, 32'h40100000,
             32'h3FC00000, 32'h40200000};
      push_exp(5, 32'h40400000, 1'b0, 1'b0);
      send_frame("after_bp", N, 1'b1, -1);
      get_result("after_bp");

      // Partial frame of huge values, reset while a beat is offered
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h7F000000;
         in_last  = 1'b0;
         tick();
      end
      chk("mid_no_valid", out_valid, 1'b0);
      in_last = 1'b1;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("rst_mid_valid", out_valid, 1'b0);
      tick();
      chk("rst_mid_valid2", out_valid, 1'b0);
      chk("rst_mid_ready", in_ready, 1'b1);
      fr = '{32'h3F800000, 32'h40200000, 32'hC0400000, 32'h00000000,
             32'h40E80000, 32'h40E00000, 32'hFF800000, 32'h006CE3EE,
             32'h40C00000, 32'h3F000000};
      push_exp(4, 32'h40E80000, 1'b0, 1'b0);
      send_frame("post_rst", N, 1'b1, -1);
      get_result("post_rst");

      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
